xor_rr_arbiter: RTL

XOR_RR_ARBITER -- requirements
Module: xor_rr_arbiter

---
 rtl/xor_arb_pkg.sv | 13 +
 rtl/rr_grant.sv | 31 +++
 rtl/xor_rr_arbiter.sv | 81 ++++++++
 3 files changed

// File: rtl/xor_arb_pkg.sv
// Shared constants and state encoding for the XOR round-robin arbiter.
package xor_arb_pkg;

    localparam int unsigned DEF_N    = 16;
    localparam int unsigned DEF_NREQ = 4;

    // The result slot is either empty or holding an undelivered result.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } arb_state_e;

endpackage : xor_arb_pkg

// File: rtl/rr_grant.sv
// Combinational round-robin picker: first asserted request at or above i_ptr, wrapping.
module rr_grant #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDW-1:0]  i_ptr,
    output logic [NREQ-1:0] o_grant,
    output logic [IDW-1:0]  o_idx
);

    logic [IDW-1:0] w_cand;
    logic           w_found;

    // Scan NREQ candidates starting at i_ptr; NREQ is a power of two so IDW-bit addition wraps.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_cand  = '0;
        w_found = 1'b0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            w_cand = i_ptr + IDW'(k);
            if (!w_found && i_req[w_cand]) begin
                w_found         = 1'b1;
                o_grant[w_cand] = 1'b1;
                o_idx           = w_cand;
            end
        end
    end

endmodule : rr_grant

// File: rtl/xor_rr_arbiter.sv
// Round-robin arbiter feeding a one-entry XOR result register with valid/ready handshakes.
module xor_rr_arbiter
    import xor_arb_pkg::*;
#(
    parameter int unsigned N    = DEF_N,
    parameter int unsigned NREQ = DEF_NREQ,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*N-1:0] req_a,
    input  logic [NREQ*N-1:0] req_b,
    output logic [NREQ-1:0]   req_ready,
    output logic              res_valid,
    output logic [N-1:0]      res_data,
    output logic [IDW-1:0]    res_id,
    input  logic              res_ready
);

    arb_state_e     r_state;
    logic [N-1:0]   r_data;
    logic [IDW-1:0] r_id;
    logic [IDW-1:0] r_ptr;

    logic [NREQ-1:0] w_grant;
    logic [IDW-1:0]  w_idx;
    logic            w_slot_free;
    logic            w_accept;
    logic [N-1:0]    w_xor;
    logic [N-1:0]    w_a [NREQ];
    logic [N-1:0]    w_b [NREQ];

    // Unpack per-requester operands.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_split
        assign w_a[gi] = req_a[gi*N +: N];
        assign w_b[gi] = req_b[gi*N +: N];
    end

    rr_grant #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_grant (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx)
    );

    // Slot can take a new result if empty or being drained this cycle; held off during reset.
    assign w_slot_free = (r_state == EMPTY) || res_ready;
    assign req_ready   = (rst_n && w_slot_free) ? w_grant : '0;
    assign w_accept    = |req_ready;
    assign w_xor       = w_a[w_idx] ^ w_b[w_idx];

    assign res_valid = (r_state == FULL);
    assign res_data  = r_data;
    assign res_id    = r_id;

    // Slot state, result capture and round-robin pointer advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= EMPTY;
            r_data  <= '0;
            r_id    <= '0;
            r_ptr   <= '0;
        end else begin
            if (r_state == EMPTY) begin
                if (w_accept) r_state <= FULL;
            end else begin
                if (res_ready && !w_accept) r_state <= EMPTY;
            end
            if (w_accept) begin
                r_data <= w_xor;
                r_id   <= w_idx;
                r_ptr  <= w_idx + IDW'(1);
            end
        end
    end

endmodule : xor_rr_arbiter
